// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out serializer.
// PARITY is always declared; it is only reachable when PISO_PARITY_EN is defined.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    // The bit counter must hold 0..n-1; keep it at least one bit wide.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a zero flag; it tracks the remaining data bits of a frame.
module piso_bit_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement so a back-to-back frame restarts cleanly.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Serializer: takes an N-bit word on a valid/ready handshake and sends it MSB first.
// Define PISO_PARITY_EN to append an even-parity bit as an extra frame cycle.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         frame_last,
    output logic         busy,
    output piso_state_e  dbg_state
);

    // Handshake: a word transfers at a rising edge where din_valid && din_ready
    // and reset is low; din must be held stable by the source until then.

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

    piso_state_e  state_q;
    piso_state_e  state_d;
    logic [N-1:0] shreg_q;
    logic [N-1:0] shreg_d;
    logic         accept;
    logic         cnt_zero;
    logic         cnt_dec;
    logic         last_data;
    logic         frame_end;
    logic [CW-1:0] cnt_val;

    assign last_data = (state_q == SHIFT) && cnt_zero;

`ifdef PISO_PARITY_EN
    logic par_q;
    logic par_d;
    assign frame_end = (state_q == PARITY);
`else
    assign frame_end = last_data;
`endif

    assign din_ready = (state_q == IDLE) || frame_end;
    assign accept    = din_valid && din_ready;
    assign cnt_dec   = (state_q == SHIFT) && !cnt_zero;

    piso_bit_counter #(.W(CW)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i (CNT_LOAD),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            state_d = SHIFT;
            shreg_d = din;
`ifdef PISO_PARITY_EN
            par_d   = ^din;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    shreg_d = {shreg_q[N-2:0], 1'b0};
                    if (cnt_zero) begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end
                end
                PARITY:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Serial outputs depend only on registered state, never on din.
    always_comb begin
        sout = 1'b0;
        case (state_q)
            SHIFT:   sout = shreg_q[N-1];
`ifdef PISO_PARITY_EN
            PARITY:  sout = par_q;
`endif
            default: sout = 1'b0;
        endcase
    end

    assign sout_valid = (state_q != IDLE);
    assign busy       = (state_q != IDLE);
    assign frame_last = frame_end;
    assign dbg_state  = state_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: expected serial bits are queued per accepted word
// and popped by a monitor on every cycle the DUT presents a frame bit.
module tb_piso_serializer;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sout;
  logic         sout_valid;
  logic         frame_last;
  logic         busy;
  logic [1:0]   dbg_state;

  piso_serializer #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame_last (frame_last),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  // Each entry: {last_data_bit, frame_last, serial_bit}
  logic [2:0]   exp_q[$];
  logic [N-1:0] word_q[$];

  logic [N-1:0] sipo;
  logic [N-1:0] sipo_word;
  bit           sipo_pending = 1'b0;

  // Companion serial-in shift register clocked on every valid bit.
  always_ff @(posedge clk) begin
    if (sout_valid) sipo <= {sipo[N-2:0], sout};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is simply the word's bits MSB first (plus parity).
  function automatic void push_frame(input logic [N-1:0] w);
    for (int i = N - 1; i >= 0; i--) begin
`ifdef PISO_PARITY_EN
      exp_q.push_back({(i == 0), 1'b0, w[i]});
`else
      exp_q.push_back({(i == 0), (i == 0), w[i]});
`endif
    end
`ifdef PISO_PARITY_EN
    exp_q.push_back({1'b0, 1'b1, ^w});
`endif
    word_q.push_back(w);
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    if (started) begin
      logic       model_ready;
      logic [2:0] e;
      model_ready = (exp_q.size() <= 1);
      chk("din_ready", din_ready, model_ready);
      chk("sout_valid", sout_valid, exp_q.size() > 0);
      chk("busy", busy, exp_q.size() > 0);
      if (sipo_pending) begin
        chk("sipo_q", sipo, sipo_word);
        sipo_pending = 1'b0;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (sout_valid) begin
          chk("sout", sout, e[0]);
          chk("frame_last", frame_last, e[1]);
        end
        if (e[2] && word_q.size() > 0) begin
          sipo_word    = word_q.pop_front();
          sipo_pending = 1'b1;
        end
      end else begin
        chk("idle_sout", sout, 1'b0);
        chk("idle_frame_last", frame_last, 1'b0);
      end
      if (reset) begin
        exp_q.delete();
        word_q.delete();
      end else if (din_valid && model_ready) begin
        push_frame(din);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] w);
    bit done;
    done = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (din_ready) done = 1'b1;
      tick();
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: word %0h not accepted within 40 cycles", w);
    end
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1;
    din = '0;
    din_valid = 1'b0;
    tick();
    started = 1'b1;
    tick();
    reset = 1'b0;
    idle(2);

    // single frame
    send_word(4'b1011);
    idle(6);

    // back-to-back frames
    send_word(4'b1011);
    send_word(4'b0110);
    idle(6);

    // stall: new word held while the current frame is still shifting
    send_word(4'b1001);
    din_valid = 1'b1;
    tick();
    send_word(4'b1111);
    idle(6);

    // reset mid-frame
    send_word(4'b1100);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(1);
    send_word(4'b0101);
    idle(6);

    // word offered during reset is dropped
    reset = 1'b1;
    din = 4'b1111;
    din_valid = 1'b1;
    tick();
    reset = 1'b0;
    din_valid = 1'b0;
    idle(3);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 11) == 0) begin
        reset = 1'b1;
        din = N'($urandom);
        din_valid = $urandom_range(0, 1) == 1;
        tick();
        reset = 1'b0;
        din_valid = 1'b0;
      end else begin
        send_word(N'($urandom));
        if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
      end
    end

    idle(1);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected bits never appeared", exp_q.size());
    end
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
